reg_dump_streamer: RTL and testbench

Debug read-out engine for the 32x32 register file. On a start request it walks every register through a register-file read port and serialises each word, MSB byte first, onto a byte-wide valid/ready stream. The stream feeds the lab-board UART/host link. It is the reader counterpart of the register-file write path and needs only one read port: `rd_addr` out, `rd_data` in (combinational).

---
 rtl/reg_dump_pkg.sv | 20 ++
 rtl/reg_dump_streamer_word_serializer.sv | 51 +++++
 rtl/reg_dump_streamer.sv | 97 +++++++++
 tb/tb_reg_dump_streamer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump streamer.
package reg_dump_pkg;

  localparam int BYTE_W         = 8;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int BYTES_PER_WORD = DATA_WIDTH_DEF / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/reg_dump_streamer_word_serializer.sv
// Parallel-load shift register that emits a word MSB byte first over valid/ready.
module word_serializer
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  valid_i,
  input  logic                  ready_i,
  output logic [BYTE_W-1:0]     data_o,
  output logic                  accept_o,
  output logic                  last_o
);

  localparam int NBYTES = bytes_per_word(DATA_WIDTH);
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         count_q, count_d;

  assign accept_o = clk_en & valid_i & ready_i;
  assign last_o   = (count_q == CW'(NBYTES - 1));
  assign data_o   = shift_q[DATA_WIDTH-1 -: BYTE_W];

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (clk_en && load_i) begin
      shift_d = load_data_i;
      count_d = '0;
    end else if (accept_o) begin
      shift_d = shift_q << BYTE_W;
      count_d = last_o ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg_dump_streamer.sv
// Walks every register through one read port and streams each word MSB byte first.
// state | meaning
// IDLE  | waiting for start; rd_addr keeps the last index read
// LOAD  | rd_addr = index, word captured into the serializer
// SEND  | bytes of the captured word offered on tx_*
// DONE  | one-cycle done pulse, then back to IDLE
module reg_dump_streamer
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  load;
  logic                  accept;
  logic                  last_byte;

  word_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .load_i     (load),
    .load_data_i(rd_data),
    .valid_i    (tx_valid),
    .ready_i    (tx_ready),
    .data_o     (tx_data),
    .accept_o   (accept),
    .last_o     (last_byte)
  );

  // Index clears on leaving IDLE so rd_addr still shows the last register while idle.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    load    = 1'b0;
    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            index_d = '0;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          load    = 1'b1;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          if (accept && last_byte) begin
            if (index_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              index_d = index_q + ADDR_WIDTH'(1);
              state_d = ST_LOAD;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  assign rd_addr  = index_q;
  assign tx_valid = (state_q == ST_SEND) & clk_en;
  assign busy     = (state_q == ST_LOAD) | (state_q == ST_SEND);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Scoreboard bench for reg_dump_streamer: expected byte stream and done timing queued at start.
module tb_reg_dump_streamer;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;
  localparam int NB   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  logic [DW-1:0] regs [NREG];
  assign rd_data = (rd_addr == '0) ? '0 : regs[rd_addr];

  reg_dump_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         done_q[$];
  int         tests = 0;
  int         fails = 0;
  int         bytes_seen = 0;
  int         dones = 0;
  int         exp_done;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every accepted byte and every done pulse against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid) check("busy_with_valid", 64'(busy), 64'd1);
      if (!clk_en) check("valid_while_ce_low", 64'(tx_valid), 64'd0);
      if (prev_stall && tx_valid) check("stall_stable", 64'(tx_data), 64'(prev_data));
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got %02h, expected no byte", tx_data);
        end else begin
          check($sformatf("byte%0d", bytes_seen), 64'(tx_data), 64'(exp_q.pop_front()));
        end
        bytes_seen++;
      end
      if (done) begin
        dones++;
        check("busy_at_done", 64'(busy), 64'd0);
        check("bytes_left_at_done", 64'(exp_q.size()), 64'd0);
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          exp_done = done_q.pop_front();
          if (exp_done >= 0) check("done_cycle", 64'(cyc), 64'(exp_done));
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One dump; called at posedge+1 with the DUT in IDLE. Negative byte indices disable a feature.
  task automatic run_dump(input string tag, input bit live, input bit extra_starts,
                          input int stall_byte, input int ce_byte, input int abort_byte,
                          input bit rnd, input int exp_extra);
    int            stall_cnt = 0;
    int            ce_cnt = 0;
    bit            w3 = 1'b0;
    bit            w20 = 1'b0;
    bit            finished = 1'b0;
    int            d0;
    logic [DW-1:0] w;
    for (int k = 0; k < NREG; k++) begin
      w = (k == 0) ? '0 : regs[k];
      if (live && k == 20) w = 32'hCAFEF00D;
      for (int b = NB - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end
    done_q.push_back(rnd ? -1 : cyc + 161 + exp_extra);
    bytes_seen = 0;
    d0 = dones;
    start = 1'b1;
    for (int t = 1; t <= 1500 && !finished; t++) begin
      @(posedge clk);
      #1;
      start    = extra_starts && (t == 20 || t == 161);
      tx_ready = 1'b1;
      clk_en   = 1'b1;
      if (rnd) begin
        tx_ready = ($urandom_range(0, 3) != 0);
        if (bytes_seen < 120 && $urandom_range(0, 9) == 0) clk_en = 1'b0;
      end
      if (bytes_seen == stall_byte && stall_cnt < 10) begin
        tx_ready = 1'b0;
        stall_cnt++;
      end
      if (bytes_seen == ce_byte && ce_cnt < 5) begin
        clk_en = 1'b0;
        ce_cnt++;
      end
      if (live && !w3 && bytes_seen >= 13) begin
        regs[3] = 32'hDEADBEEF;
        w3 = 1'b1;
      end
      if (live && !w20 && bytes_seen >= 40) begin
        regs[20] = 32'hCAFEF00D;
        w20 = 1'b1;
      end
      if (t == 1) begin
        check({tag, "_busy_in_load"}, 64'(busy), 64'd1);
        check({tag, "_rd_addr_in_load"}, 64'(rd_addr), 64'd0);
      end
      if (bytes_seen == abort_byte) begin
        #2;
        reset = 1'b1;
        #1;
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        finished = 1'b1;
      end
      if (dones != d0) finished = 1'b1;
    end
    if (!finished) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d bytes, expected completion within 1500 cycles", tag, bytes_seen);
    end
  endtask

  initial begin
    reset    = 1'b1;
    clk_en   = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < NREG; k++) regs[k] = {4{8'(k)}};
    regs[1] = 32'h11223344;
    regs[5] = 32'hA1B2C3D4;
    #12;
    check("reset_tx_valid", 64'(tx_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_rd_addr", 64'(rd_addr), 64'd0);
    check("reset_tx_data", 64'(tx_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_dump("full_live", 1'b1, 1'b1, -1, -1, -1, 1'b0, 0);
    run_dump("backpressure", 1'b0, 1'b0, 22, -1, -1, 1'b0, 10);
    run_dump("clk_en", 1'b0, 1'b0, -1, 50, -1, 1'b0, 5);
    run_dump("abort", 1'b0, 1'b0, -1, -1, 30, 1'b0, 0);
    run_dump("after_reset", 1'b0, 1'b0, -1, -1, -1, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NREG; k++) regs[k] = $urandom();
      run_dump($sformatf("rand%0d", r), 1'b0, 1'b0, -1, -1, -1, 1'b1, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_dones", 64'(dones), 64'd8);
    check("final_bytes_pending", 64'(exp_q.size()), 64'd0);
    check("final_done_pending", 64'(done_q.size()), 64'd0);
    check("final_busy", 64'(busy), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
